// File: rtl/mc_traffic_checker_if.sv
// Front-end request/return port shared by the traffic checker (master) and memory_controller (slave).
interface mc_traffic_checker_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 30
);
    logic              in_valid;
    logic              in_request_type;
    logic [ADDR_W-1:0] in_request_address;
    logic [DATA_W-1:0] in_request_data;
    logic              out_busy;
    logic              read_done;
    logic [DATA_W-1:0] data_out;

    modport master (
        output in_valid, in_request_type, in_request_address, in_request_data,
        input  out_busy, read_done, data_out
    );

    modport slave (
        input  in_valid, in_request_type, in_request_address, in_request_data,
        output out_busy, read_done, data_out
    );
endinterface

// File: rtl/mc_traffic_checker.sv
// Restartable traffic generator: writes NUM_REQ address-derived words, reads them back in
// issue order and counts mismatches, spurious returns and watchdog expiry.
module mc_traffic_checker #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 30,
    parameter int                NUM_REQ   = 1024,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter logic [DATA_W-1:0] SEED      = '0,
    parameter int                TIMEOUT   = 200,
    parameter int                ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    mc_traffic_checker_if.master mc,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     error_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [31:0]          cycle_count
);
    localparam int               CNT_W = $clog2(NUM_REQ + 1);
    localparam int               WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic             mode_q;
    logic [CNT_W-1:0] req_idx;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] exp_ptr;
    logic [WD_W-1:0]  wd_cnt;
    logic             mismatch_seen;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] k);
        return ADDR_BASE + ADDR_W'(k);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [CNT_W-1:0] k);
        return DATA_W'(addr_of(k)) ^ SEED;
    endfunction

    logic xfer, rd_accept, ret_ok, spurious, mismatch, start_ok, wd_reload, wd_expire;

    assign xfer      = mc.in_valid && !mc.out_busy;
    assign rd_accept = xfer && !mc.in_request_type;
    assign ret_ok    = mc.read_done && (outstanding != '0);
    assign spurious  = mc.read_done && (outstanding == '0);
    assign mismatch  = ret_ok && (mc.data_out != pattern(exp_ptr));
    assign start_ok  = start && !busy;
    assign wd_reload = start_ok || xfer || mc.read_done;
    assign wd_expire = busy && !wd_reload && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign pass      = done && (error_count == '0) && !timeout;

    // Successor of the request currently presented; nxt_end marks the final read.
    logic             nxt_type, nxt_end;
    logic [CNT_W-1:0] nxt_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        nxt_type = 1'b0;
        nxt_idx  = req_idx;
        nxt_end  = 1'b0;
        if (mc.in_request_type) begin
            if (mode_q) begin
                nxt_type = 1'b0;
            end else if (req_idx == LAST) begin
                nxt_type = 1'b0;
                nxt_idx  = '0;
            end else begin
                nxt_type = 1'b1;
                nxt_idx  = req_idx + CNT_W'(1);
            end
        end else if (req_idx == LAST) begin
            nxt_end = 1'b1;
        end else begin
            nxt_type = mode_q;
            nxt_idx  = req_idx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            mode_q                <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            timeout               <= 1'b0;
            mc.in_valid           <= 1'b0;
            mc.in_request_type    <= 1'b0;
            mc.in_request_address <= '0;
            mc.in_request_data    <= '0;
            req_idx               <= '0;
            outstanding           <= '0;
            exp_ptr               <= '0;
            wd_cnt                <= '0;
            error_count           <= '0;
            first_err_addr        <= '0;
            mismatch_seen         <= 1'b0;
            cycle_count           <= '0;
        end else begin
            // Return checking runs in every state so strays in IDLE/DONE are still counted.
            unique case ({rd_accept, ret_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
            if (ret_ok) exp_ptr <= exp_ptr + CNT_W'(1);
            if ((mismatch || spurious) && (error_count != '1)) error_count <= error_count + ERR_W'(1);
            if (mismatch && !mismatch_seen) begin
                mismatch_seen  <= 1'b1;
                first_err_addr <= addr_of(exp_ptr);
            end
            if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
            if (wd_reload)  wd_cnt <= '0;
            else if (busy)  wd_cnt <= wd_cnt + WD_W'(1);

            // NOTE: the start branch below is later in the block, so its clears win over the updates above.
            unique case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state                 <= ISSUE;
                        mode_q                <= mode;
                        busy                  <= 1'b1;
                        done                  <= 1'b0;
                        timeout               <= 1'b0;
                        mc.in_valid           <= 1'b1;
                        mc.in_request_type    <= 1'b1;
                        mc.in_request_address <= addr_of('0);
                        mc.in_request_data    <= pattern('0);
                        req_idx               <= '0;
                        outstanding           <= '0;
                        exp_ptr               <= '0;
                        error_count           <= '0;
                        first_err_addr        <= '0;
                        mismatch_seen         <= 1'b0;
                        cycle_count           <= '0;
                    end
                end
                ISSUE: begin
                    if (wd_expire) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                        mc.in_valid <= 1'b0;
                    end else if (xfer) begin
                        if (nxt_end) begin
                            state       <= DRAIN;
                            mc.in_valid <= 1'b0;
                        end else begin
                            req_idx               <= nxt_idx;
                            mc.in_request_type    <= nxt_type;
                            mc.in_request_address <= addr_of(nxt_idx);
                            mc.in_request_data    <= nxt_type ? pattern(nxt_idx) : '0;
                        end
                    end
                end
                DRAIN: begin
                    if (wd_expire) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (outstanding == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_traffic_checker.sv
// Self-checking bench: a controller model with optional back-pressure, corruption and dropped
// returns drives the main instance; a NUM_REQ=1 instance is exercised by hand.
`timescale 1ns/1ps
module tb_mc_traffic_checker;
    localparam int                DATA_W  = 16;
    localparam int                ADDR_W  = 30;
    localparam int                NUM_REQ = 1024;
    localparam int                IDX_W   = 10;
    localparam int                TIMEOUT = 200;
    localparam int                ERR_W   = 16;
    localparam logic [DATA_W-1:0] SEED    = 16'h5A3C;
    localparam logic [DATA_W-1:0] SEED1   = 16'h1234;
    localparam logic [ADDR_W-1:0] BASE1   = '1;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, mode = 1'b0;
    logic o_start = 1'b0, o_mode = 1'b0;
    logic mdl_busy = 1'b0, mdl_rd = 1'b0, spur_rd = 1'b0;
    logic [DATA_W-1:0] mdl_data = '0;
    logic one_rd = 1'b0;
    logic [DATA_W-1:0] one_data = '0;

    always #5 clk = ~clk;

    mc_traffic_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();
    mc_traffic_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) oif ();

    assign mif.out_busy  = mdl_busy;
    assign mif.read_done = mdl_rd | spur_rd;
    assign mif.data_out  = mdl_data;
    assign oif.out_busy  = 1'b0;
    assign oif.read_done = one_rd;
    assign oif.data_out  = one_data;

    logic              d_busy, d_done, d_pass, d_timeout;
    logic [ERR_W-1:0]  d_err;
    logic [ADDR_W-1:0] d_first;
    logic [31:0]       d_cycles;
    logic              o_busy, o_done, o_pass, o_timeout;
    logic [ERR_W-1:0]  o_err;
    logic [ADDR_W-1:0] o_first;
    logic [31:0]       o_cycles;

    mc_traffic_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ), .ADDR_BASE('0),
        .SEED(SEED), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .mc(mif.master),
        .busy(d_busy), .done(d_done), .pass(d_pass), .timeout(d_timeout),
        .error_count(d_err), .first_err_addr(d_first), .cycle_count(d_cycles)
    );

    mc_traffic_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REQ(1), .ADDR_BASE(BASE1),
        .SEED(SEED1), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
    ) u_one (
        .clk(clk), .rst(rst), .start(o_start), .mode(o_mode), .mc(oif.master),
        .busy(o_busy), .done(o_done), .pass(o_pass), .timeout(o_timeout),
        .error_count(o_err), .first_err_addr(o_first), .cycle_count(o_cycles)
    );

    typedef struct {
        bit mode;
        int busy_pct;
        int bad_a;
        int bad_b;
        bit drop_last;
        int exp_err;
        int exp_first;
        bit exp_pass;
        bit exp_to;
    } scen_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, last_rd_cyc = 0;
    int n_xfer, n_ret, seq_err, stab_err;
    int busy_pct = 0, bad_a = -1, bad_b = -1;
    bit drop_last = 1'b0, run_mode = 1'b0, held = 1'b0;
    logic              held_type;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    logic [DATA_W-1:0] mem [NUM_REQ];
    ret_t              rq [$];
    scen_t             tbl [7];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Request n of a run: mode 0 is all writes then all reads, mode 1 alternates W(k),R(k).
    function automatic void exp_req(input bit m, input int n, output bit w, output int k);
        if (!m) begin
            w = (n < NUM_REQ);
            k = w ? n : n - NUM_REQ;
        end else begin
            w = (n % 2 == 0);
            k = n / 2;
        end
    endfunction

    // One cycle of the controller model: sample DUT at negedge, drive for the next posedge (cyc).
    task automatic tick();
        bit                w;
        int                k;
        logic [DATA_W-1:0] rdat;
        @(negedge clk);
        cyc++;
        if (held && (mif.in_valid !== 1'b1 || mif.in_request_type !== held_type ||
                     mif.in_request_address !== held_addr || mif.in_request_data !== held_data))
            stab_err++;
        mdl_busy  = (busy_pct > 0) && ($urandom_range(99) < busy_pct);
        held      = (mif.in_valid === 1'b1) && mdl_busy;
        held_type = mif.in_request_type;
        held_addr = mif.in_request_address;
        held_data = mif.in_request_data;
        if (mif.in_valid === 1'b1 && !mdl_busy) begin
            if (n_xfer >= 2 * NUM_REQ) begin
                seq_err++;
            end else begin
                exp_req(run_mode, n_xfer, w, k);
                if (mif.in_request_type !== w || mif.in_request_address !== ADDR_W'(k) ||
                    mif.in_request_data !== (w ? (DATA_W'(k) ^ SEED) : '0))
                    seq_err++;
            end
            if (mif.in_request_type === 1'b1) begin
                mem[mif.in_request_address[IDX_W-1:0]] = mif.in_request_data;
            end else if (!(drop_last && int'(mif.in_request_address) == NUM_REQ - 1)) begin
                rdat = mem[mif.in_request_address[IDX_W-1:0]];
                if (int'(mif.in_request_address) == bad_a || int'(mif.in_request_address) == bad_b)
                    rdat[0] = ~rdat[0];
                rq.push_back('{due: cyc + 3, data: rdat});
            end
            n_xfer++;
        end
        mdl_rd = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mdl_rd      = 1'b1;
            mdl_data    = rq[0].data;
            last_rd_cyc = cyc;
            n_ret++;
            rq.delete(0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_valid"}, mif.in_valid, 0);
        check({tag, "_req_type"}, mif.in_request_type, 0);
        check({tag, "_req_addr"}, mif.in_request_address, 0);
        check({tag, "_req_data"}, mif.in_request_data, 0);
        check({tag, "_busy"}, d_busy, 0);
        check({tag, "_done"}, d_done, 0);
        check({tag, "_pass"}, d_pass, 0);
        check({tag, "_timeout"}, d_timeout, 0);
        check({tag, "_err"}, d_err, 0);
        check({tag, "_first"}, d_first, 0);
        check({tag, "_cycles"}, d_cycles, 0);
    endtask

    task automatic begin_run(input scen_t s);
        run_mode  = s.mode;
        busy_pct  = s.busy_pct;
        bad_a     = s.bad_a;
        bad_b     = s.bad_b;
        drop_last = s.drop_last;
        n_xfer    = 0;
        n_ret     = 0;
        seq_err   = 0;
        stab_err  = 0;
        held      = 1'b0;
        rq.delete();
        mode      = s.mode;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        mode  = ~s.mode;
        check("start_busy", d_busy, 1);
        check("start_done_clr", d_done, 0);
        check("start_to_clr", d_timeout, 0);
        check("start_err_clr", d_err, 0);
    endtask

    task automatic finish_run(input string tag, input scen_t s);
        int budget;
        bit got;
        budget = 20000;
        got    = 1'b0;
        while (!got && budget > 0) begin
            if (d_done === 1'b1) got = 1'b1;
            else begin
                tick();
                budget--;
            end
        end
        check({tag, "_done_reached"}, got, 1);
        check({tag, "_pass"}, d_pass, s.exp_pass);
        check({tag, "_timeout"}, d_timeout, s.exp_to);
        check({tag, "_err"}, d_err, s.exp_err);
        check({tag, "_first"}, d_first, s.exp_first);
        check({tag, "_in_valid"}, mif.in_valid, 0);
        check({tag, "_busy"}, d_busy, 0);
        check({tag, "_xfers"}, n_xfer, 2 * NUM_REQ);
        check({tag, "_returns"}, n_ret, NUM_REQ - int'(s.drop_last));
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_stable_err"}, stab_err, 0);
        check({tag, "_cycles"}, d_cycles, cyc - 1 - start_cyc);
        if (s.drop_last) check({tag, "_wd_gap"}, cyc - 1 - last_rd_cyc, TIMEOUT);
    endtask

    initial begin
        scen_t s;
        tbl[0] = '{1'b0,  0,  -1,  -1, 1'b0, 0,   0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 50,  -1,  -1, 1'b0, 0,   0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 50,  -1,  -1, 1'b0, 0,   0, 1'b1, 1'b0};
        tbl[3] = '{1'b0,  0,  37, 500, 1'b0, 2,  37, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 30, 500,  -1, 1'b0, 1, 500, 1'b0, 1'b0};
        tbl[5] = '{1'b0,  0,  -1,  -1, 1'b1, 0,   0, 1'b0, 1'b1};
        tbl[6] = '{1'b1,  0,  -1,  -1, 1'b0, 0,   0, 1'b1, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");
        check("reset_one_valid", oif.in_valid, 0);
        check("reset_one_busy", o_busy, 0);

        for (int i = 0; i < 7; i++) begin
            begin_run(tbl[i]);
            finish_run($sformatf("s%0d", i), tbl[i]);
        end

        // Reset mid-ISSUE, with an ignored start pulse on the way.
        s = '{1'b0, 0, -1, -1, 1'b0, 0, 0, 1'b1, 1'b0};
        begin_run(s);
        for (int g = 0; g < 1000 && n_xfer < 100; g++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 1000 && n_xfer < 300; g++) tick();
        check("mid_seq_err", seq_err, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        rq.delete();
        repeat (3) tick();
        check("idle_stays_valid", mif.in_valid, 0);
        check("idle_stays_busy", d_busy, 0);

        // Stray return in IDLE, then a clean rerun from the base address.
        spur_rd = 1'b1;
        tick();
        spur_rd = 1'b0;
        tick();
        check("spur_err", d_err, 1);
        check("spur_pass", d_pass, 0);
        begin_run(tbl[1]);
        finish_run("rerun", tbl[1]);

        // NUM_REQ=1 instance, both modes; second pass restarts from DONE.
        for (int m = 0; m < 2; m++) begin
            o_mode  = (m == 1);
            o_start = 1'b1;
            tick();
            o_start = 1'b0;
            check("one_w_valid", oif.in_valid, 1);
            check("one_w_type", oif.in_request_type, 1);
            check("one_w_addr", oif.in_request_address, BASE1);
            check("one_w_data", oif.in_request_data, 16'hEDCB);
            tick();
            check("one_r_valid", oif.in_valid, 1);
            check("one_r_type", oif.in_request_type, 0);
            check("one_r_addr", oif.in_request_address, BASE1);
            check("one_r_data", oif.in_request_data, 0);
            tick();
            check("one_drain_valid", oif.in_valid, 0);
            check("one_drain_busy", o_busy, 1);
            one_rd   = 1'b1;
            one_data = 16'hEDCB;
            tick();
            one_rd = 1'b0;
            tick();
            check("one_done", o_done, 1);
            check("one_pass", o_pass, 1);
            check("one_err", o_err, 0);
            check("one_busy", o_busy, 0);
            check("one_cycles", o_cycles, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
